// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler CPU status flags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibbler_pkg;

    // Bit positions of the flags inside a flags_t word.
    localparam int FLAG_C_IDX = 1;
    localparam int FLAG_Z_IDX = 0;

    typedef logic [1:0] flags_t;

    // Both flags clear after reset.
    localparam flags_t FLAGS_RESET = 2'b00;

endpackage : nibbler_pkg

// File: rtl/flag_bit.sv
// Single status-flag flip-flop with asynchronous active-high reset.
// Latency: d appears on q one rising clk edge later; reset acts immediately.
// Backpressure: none, the bit is written on every edge.
//
// Ports:
//   clk - capture clock (rising edge)
//   rst - asynchronous active-high reset, forces q to RESET_VALUE
//   d   - next flag value
//   q   - stored flag, driven straight from the flop
module flag_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : flag_bit

// File: rtl/flags_register.sv
// Nibbler CPU carry/zero status register between the ALU and the branch decoder.
// Latency: c/z appear on flags_out one rising clk edge later; reset acts immediately.
// Backpressure: none, both flags are captured on every edge with no enable.
//
// Ports:
//   clk       - system clock (rising edge)
//   reset     - asynchronous active-high reset, forces flags_out to RESET_VALUE
//   c         - ALU carry out
//   z         - ALU zero result
//   flags_out - registered flags, bit 1 = C, bit 0 = Z
module flags_register
    import nibbler_pkg::*;
#(
    parameter flags_t RESET_VALUE = FLAGS_RESET
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   c,
    input  logic   z,
    output flags_t flags_out
);

    logic w_c_q;
    logic w_z_q;

    // Each flag keeps its own slice of RESET_VALUE so the two bits stay independent.
    flag_bit #(
        .RESET_VALUE (RESET_VALUE[FLAG_C_IDX])
    ) u_flag_c (
        .clk (clk),
        .rst (reset),
        .d   (c),
        .q   (w_c_q)
    );

    flag_bit #(
        .RESET_VALUE (RESET_VALUE[FLAG_Z_IDX])
    ) u_flag_z (
        .clk (clk),
        .rst (reset),
        .d   (z),
        .q   (w_z_q)
    );

    always_comb begin
        flags_out             = '0;
        flags_out[FLAG_C_IDX] = w_c_q;
        flags_out[FLAG_Z_IDX] = w_z_q;
    end

endmodule : flags_register

// File: tb/tb_flags_register.sv
module tb_flags_register;

    logic       clk;
    logic       reset;
    logic       c;
    logic       z;
    logic [1:0] flags_out;
    logic [1:0] flags_out_alt;

    int n_checks;
    int n_fail;

    // Reference: the register holds whatever {c,z} was present at the last
    // rising edge taken with reset low, or the reset value whenever reset is high.
    localparam logic [1:0] RV_DFLT = 2'b00;
    localparam logic [1:0] RV_ALT  = 2'b10;
    logic [1:0] exp_dflt;
    logic [1:0] exp_alt;

    flags_register dut (
        .clk       (clk),
        .reset     (reset),
        .c         (c),
        .z         (z),
        .flags_out (flags_out)
    );

    flags_register #(
        .RESET_VALUE (RV_ALT)
    ) dut_alt (
        .clk       (clk),
        .reset     (reset),
        .c         (c),
        .z         (z),
        .flags_out (flags_out_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check_val({tag, "/dflt"}, flags_out, exp_dflt);
        check_val({tag, "/alt"}, flags_out_alt, exp_alt);
    endtask

    // Take one rising edge, update the reference from the values present at it,
    // then step just past the edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            exp_dflt = RV_DFLT;
            exp_alt  = RV_ALT;
        end else begin
            exp_dflt = {c, z};
            exp_alt  = {c, z};
        end
        #1;
    endtask

    task automatic assert_reset_now();
        reset    = 1'b1;
        exp_dflt = RV_DFLT;
        exp_alt  = RV_ALT;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        c        = 1'b1;
        z        = 1'b1;
        exp_dflt = 2'bxx;
        exp_alt  = 2'bxx;

        // Reset before any clock edge: output must follow reset asynchronously.
        #1;
        assert_reset_now();
        check_both("reset_no_clk");

        // Reset held across edges with c=z=1 keeps the reset value.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_both("reset_held");
        end

        // Release mid-cycle with c=z=0.
        @(negedge clk);
        c     = 1'b0;
        z     = 1'b0;
        reset = 1'b0;
        #1;
        check_both("release_no_edge");
        tick();
        check_both("release_capture_00");

        // Carry only, set mid-cycle: no change until the edge.
        @(negedge clk);
        c = 1'b1;
        z = 1'b0;
        #1;
        check_both("carry_before_edge");
        tick();
        check_both("carry_only_10");

        // Zero only.
        @(negedge clk);
        c = 1'b0;
        z = 1'b1;
        tick();
        check_both("zero_only_01");

        // Both set, then clear.
        @(negedge clk);
        c = 1'b1;
        z = 1'b1;
        tick();
        check_both("both_11");
        @(negedge clk);
        c = 1'b0;
        z = 1'b0;
        tick();
        check_both("clear_00");

        // Async reset pulse between edges from 11.
        @(negedge clk);
        c = 1'b1;
        z = 1'b1;
        tick();
        check_both("pre_pulse_11");
        @(negedge clk);
        assert_reset_now();
        check_both("pulse_immediate");
        #2;
        reset = 1'b0;
        #1;
        check_both("pulse_released_no_edge");
        c = 1'b0;
        z = 1'b1;
        tick();
        check_both("pulse_recapture");

        // Stability: toggle inputs repeatedly between edges.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            c = ~c;
            z = (i % 2 == 0) ? ~z : z;
            #1;
            check_both("stable_between_edges");
        end
        tick();
        check_both("stable_final_capture");

        // Randomized traffic with occasional mid-cycle reset pulses,
        // some of which are held across the next edge.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            c = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                assert_reset_now();
                check_both("rand_async_reset");
                if ($urandom_range(0, 1) == 0) begin
                    #1;
                    reset = 1'b0;
                end
            end else begin
                reset = 1'b0;
                #1;
                check_both("rand_hold");
            end
            tick();
            check_both("rand_edge");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flags_register
